// File: rtl/reg_value_uart_tx.sv
// reg_value_uart_tx
// Watches register1Value and, whenever it differs from the last value sent,
// transmits it on a UART line as uppercase ASCII hex (MS nibble first) followed
// by a line feed. Character framing is start(0), 8 data bits LSB first, an
// optional even-parity bit, stop(1). There is no gap between characters.
//
// Optional feature macro: PARITY_EN
//   defined   : each character carries an even-parity bit (11-bit characters)
//   undefined : plain 8N1 (10-bit characters)
//
// Ports
//   clock          in   system clock, rising edge
//   isResetN       in   asynchronous active-low reset
//   register1Value in   value to monitor (REGISTER_WIDTH bits, synchronous)
//   txSerial       out  UART line, idles high
//   txBusy         out  high from first start bit to end of the LF stop bit
//   frameCount     out  completed frames, 16-bit wrapping
module reg_value_uart_tx #(
  parameter int REGISTER_WIDTH = 8,
  parameter int CLOCKS_PER_BIT = 434
) (
  input  logic                      clock,
  input  logic                      isResetN,
  input  logic [REGISTER_WIDTH-1:0] register1Value,
  output logic                      txSerial,
  output logic                      txBusy,
  output logic [15:0]               frameCount
);

  localparam int NCHARS = REGISTER_WIDTH / 4;
  localparam int CIW    = $clog2(NCHARS + 1);
  localparam int BW     = $clog2(CLOCKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                    state_q, state_d;
  logic [BW-1:0]             baud_q, baud_d;
  logic [2:0]                bit_q, bit_d;
  logic [CIW-1:0]            char_q, char_d;
  logic [REGISTER_WIDTH-1:0] shadow_q, shadow_d;
  logic [REGISTER_WIDTH-1:0] last_q, last_d;
  logic [15:0]               frame_q, frame_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;

  logic                      bit_end;
  logic [7:0]                next_char;

  // ASCII for character idx of a frame: hex digits MS nibble first, then LF.
  function automatic logic [7:0] char_of(input logic [REGISTER_WIDTH-1:0] v,
                                         input logic [CIW-1:0] idx);
    logic [3:0] nib;
    logic [7:0] c;
    nib = 4'h0;
    for (int k = 0; k < NCHARS; k++)
      if (idx == CIW'(k)) nib = v[4*(NCHARS-1-k) +: 4];
    if (idx == CIW'(NCHARS))  c = 8'h0A;
    else if (nib < 4'd10)     c = 8'h30 + {4'h0, nib};
    else                      c = 8'h37 + {4'h0, nib};
    return c;
  endfunction

  assign bit_end = (baud_q == BW'(CLOCKS_PER_BIT - 1));

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    char_d   = char_q;
    shadow_d = shadow_q;
    last_d   = last_q;
    frame_d  = frame_q;

    case (state_q)
      IDLE: begin
        if (register1Value != last_q) begin
          shadow_d = register1Value;
          last_d   = register1Value;
          char_d   = '0;
          baud_d   = '0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (char_q == CIW'(NCHARS)) begin
            frame_d = frame_q + 16'd1;
            state_d = IDLE;
          end else begin
            char_d  = char_q + 1'b1;
            state_d = START;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line and busy are registered from the next state so they change on the
  // same edge as the state that owns them.
  always_comb begin
    next_char = char_of(shadow_d, char_d);
    tx_d      = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = next_char[bit_d];
      PARITY:  tx_d = ^next_char;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      char_q   <= '0;
      shadow_q <= '0;
      last_q   <= '0;
      frame_q  <= 16'd0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      char_q   <= char_d;
      shadow_q <= shadow_d;
      last_q   <= last_d;
      frame_q  <= frame_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign txSerial   = tx_q;
  assign txBusy     = busy_q;
  assign frameCount = frame_q;

endmodule

// File: tb/tb_reg_value_uart_tx.sv
// Bench for reg_value_uart_tx: per-cycle waveform model plus a UART decoder
// with literal expected characters.
module tb_reg_value_uart_tx;
  localparam int CPB = 4;
  localparam int RW  = 8;
  localparam int NCH = RW / 4;
`ifdef PARITY_EN
  localparam int NB = 10;
  localparam int FRAME_LEN = 132;
`else
  localparam int NB = 9;
  localparam int FRAME_LEN = 120;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [RW-1:0] val = '0;
  logic          tx, busy;
  logic [15:0]   fc;

  always #5 clk = ~clk;

  reg_value_uart_tx #(.REGISTER_WIDTH(RW), .CLOCKS_PER_BIT(CPB)) dut (
    .clock(clk), .isResetN(rst_n), .register1Value(val),
    .txSerial(tx), .txBusy(busy), .frameCount(fc)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- model: expected line value per cycle ----------------
  bit            mq[$];
  logic          m_tx = 1'b1, m_busy = 1'b0;
  logic [15:0]   m_cnt = '0;
  logic [RW-1:0] m_last = '0;
  bit            m_idle = 1'b1;

  function automatic logic [7:0] hexc(int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  function automatic void push_frame(logic [RW-1:0] v);
    logic [7:0] c;
    bit bits[$];
    for (int k = 0; k <= NCH; k++) begin
      c = (k == NCH) ? 8'h0A : hexc(int'((v >> (4 * (NCH - 1 - k))) & 'hF));
      bits.delete();
      bits.push_back(1'b0);
      for (int b = 0; b < 8; b++) bits.push_back(c[b]);
`ifdef PARITY_EN
      bits.push_back(^c);
`endif
      bits.push_back(1'b1);
      foreach (bits[i]) for (int r = 0; r < CPB; r++) mq.push_back(bits[i]);
    end
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete(); m_idle = 1; m_last = '0; m_cnt = '0; m_tx = 1; m_busy = 0;
    end else if (mq.size() > 0) begin
      m_tx = mq.pop_front(); m_busy = 1; m_idle = 0;
    end else if (!m_idle) begin
      // edge ending the LF stop bit
      m_idle = 1; m_cnt++; m_tx = 1; m_busy = 0;
    end else if (val != m_last) begin
      m_last = val; push_frame(val);
      m_tx = mq.pop_front(); m_busy = 1; m_idle = 0;
    end else begin
      m_tx = 1; m_busy = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("model_tx", tx, m_tx);
    chk("model_busy", busy, m_busy);
    chk("model_frameCount", fc, m_cnt);
  end

  // ---------------- UART decoder ----------------
  logic [7:0] rx_q[$];
  bit         rx_par[$];

  initial forever begin
    logic [NB-1:0] bits;
    bit ok;
    @(negedge clk);
    if (rst_n && tx === 1'b0) begin
      ok = 1;
      bits = '0;
      for (int i = 0; i < NB && ok; i++) begin
        for (int w = 0; w < ((i == 0) ? CPB + CPB / 2 - 1 : CPB); w++) begin
          @(negedge clk);
          if (!rst_n) begin ok = 0; break; end
        end
        if (ok) bits[i] = tx;
      end
      if (ok) begin
        rx_q.push_back(bits[7:0]);
`ifdef PARITY_EN
        rx_par.push_back(bits[8]);
`endif
        chk("stop_bit", {31'd0, bits[NB-1]}, 32'd1);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk_rx(string nm, int n, logic [47:0] e);
    chk({nm, "_count"}, rx_q.size(), n);
    for (int k = 0; k < n && k < rx_q.size(); k++)
      chk(nm, {24'd0, rx_q[k]}, {24'd0, e[8*(n-1-k) +: 8]});
    rx_q.delete();
    rx_par.delete();
  endtask

  task automatic wait_busy(string nm);
    int n = 0;
    while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk(nm, {31'd0, busy}, 32'd1);
  endtask

  initial begin
    int n;
    rst_n = 0; val = 8'h00;
    cyc(5);
    rst_n = 1;

    // reset state, zero value sends nothing
    cyc(200);
    chk("idle_tx", tx, 1);
    chk("idle_busy", busy, 0);
    chk("idle_fc", fc, 0);
    chk("idle_rx", rx_q.size(), 0);

    // single frame
    val = 8'h3C;
    wait_busy("single_busy_rise");
    n = 0;
    while (busy === 1'b1 && n < 1000) begin n++; @(negedge clk); end
    chk("frame_len", n, FRAME_LEN);
    cyc(5);
    chk_rx("single", 3, 48'h0000_0033430A);
    chk("single_fc", fc, 1);

    // coalescing after a fresh reset
    rst_n = 0; cyc(3); rst_n = 1;
    rx_q.delete(); rx_par.delete();
    val = 8'h12; cyc(30);
    val = 8'h34; cyc(30);
    val = 8'h56; cyc(400);
    chk_rx("coalesce", 6, 48'h31320A35360A);
    chk("coalesce_fc", fc, 2);

    // revert during frame
    val = 8'hA0; cyc(30);
    val = 8'h56; cyc(400);
    chk_rx("revert", 6, 48'h41300A35360A);
    chk("revert_fc", fc, 4);

    // reset during data bits of the second character
    val = 8'h3C;
    wait_busy("midreset_busy_rise");
    repeat (55) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("midreset_tx", tx, 1);
    chk("midreset_busy", busy, 0);
    chk("midreset_fc", fc, 0);
    cyc(3); rst_n = 1;
    rx_q.delete(); rx_par.delete();
    cyc(300);
    chk_rx("after_reset", 3, 48'h0000_0033430A);
    chk("after_reset_fc", fc, 1);

    // value 0x07 (parity pattern 0,1,0 when enabled)
    val = 8'h07; cyc(300);
`ifdef PARITY_EN
    chk("par_count", rx_par.size(), 3);
    if (rx_par.size() >= 3) begin
      chk("par_30", {31'd0, rx_par[0]}, 0);
      chk("par_37", {31'd0, rx_par[1]}, 1);
      chk("par_0A", {31'd0, rx_par[2]}, 0);
    end
`endif
    chk_rx("x07", 3, 48'h0000_0030370A);
    chk("x07_fc", fc, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
